// File: rtl/data_memory_banked_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_banked_pkg
// Shared definitions for the banked data memory:
//   - LANE_W    : width of one byte lane
//   - state_t   : controller state (CLEAR sweep or IDLE serving requests)
//   - params_ok : legality check for the memory geometry, used at
//                 elaboration time by the top level
// ---------------------------------------------------------------------------
package data_memory_banked_pkg;

    localparam int LANE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Word width must be a whole number of byte lanes, and the array must
    // hold at least two words while still being addressable by ADDR_W bits.
    function automatic bit params_ok(input int data_w, input int depth, input int addr_w);
        return (data_w > 0) && ((data_w % LANE_W) == 0) &&
               (depth >= 2) && (longint'(depth) <= (64'd1 << addr_w));
    endfunction

endpackage

// File: rtl/data_memory_banked_lane.sv
// ---------------------------------------------------------------------------
// mem_lane_array
// One byte lane of the data memory: a DEPTH x 8 RAM with a write enable and a
// synchronous read. The read register only updates when re is high, so the
// last read value is held between reads. The array has no reset so it maps
// onto block/distributed RAM.
// Ports:
//   clk   - clock
//   we    - write enable for this lane
//   re    - read enable (captures mem[addr] on the rising edge)
//   addr  - word index, shared by read and write (single port)
//   wdata - lane write data
//   rdata - registered lane read data
// ---------------------------------------------------------------------------
module mem_lane_array
    import data_memory_banked_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_banked.sv
// ---------------------------------------------------------------------------
// data_memory_banked
// Parametrised single-port data memory with byte-lane write masking, a
// registered read port behind a valid/ready request handshake, an
// out-of-range error flag, and a sequential clear sweep (one word per cycle)
// started by reset or by clear_req.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   clear_req             - one-cycle pulse, starts a clear sweep from IDLE
//   busy                  - high while the clear sweep runs
//   req_valid/req_ready   - request handshake (ready is combinational)
//   req_write             - 1 = write, 0 = read
//   req_addr              - word address
//   req_wdata/req_wmask   - write data and per-byte-lane write enables
//   rsp_valid             - one-cycle pulse per accepted read
//   rsp_rdata             - read data (0 for an out-of-range read)
//   rsp_err               - accepted read addressed a word >= DEPTH
// ---------------------------------------------------------------------------
module data_memory_banked
    import data_memory_banked_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int DEPTH  = 256,
    localparam int LANES  = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_wmask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    if (!params_ok(DATA_W, DEPTH, ADDR_W)) begin : g_bad_params
        $error("data_memory_banked: DATA_W must be a multiple of 8 and 2 <= DEPTH <= 2**ADDR_W");
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic              accept;
    logic              in_range;
    logic              rd_en;
    logic [IDX_W-1:0]  ram_addr;
    logic [LANES-1:0]  lane_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // A pending clear_req wins over a request arriving in the same cycle.
    assign req_ready = (state_q == IDLE) && !clear_req;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
    assign rd_en     = accept && !req_write && in_range;
    assign busy      = (state_q == CLEAR);

    // Next-state logic: the sweep walks clr_addr to DEPTH-1 and then hands
    // over to IDLE; the response flags update only on an accepted read.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + IDX_W'(1);
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
        if (accept && !req_write) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !in_range;
            rsp_zero_d  = !in_range;
        end
    end

    // rsp_zero forces rsp_rdata to 0 after reset and after an out-of-range
    // read, without needing a reset on the RAM read registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_zero_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    // The single RAM port is owned by the sweep while busy, else by requests.
    assign ram_addr  = busy ? clr_addr_q : req_addr[IDX_W-1:0];
    assign ram_wdata = busy ? '0 : req_wdata;
    assign lane_we   = busy ? '1 :
                       (accept && req_write && in_range) ? req_wmask : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_lane_array #(
            .IDX_W (IDX_W),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .re    (rd_en),
            .addr  (ram_addr),
            .wdata (ram_wdata[i*LANE_W +: LANE_W]),
            .rdata (ram_rdata[i*LANE_W +: LANE_W])
        );
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_zero_q ? '0 : ram_rdata;

endmodule
